// File: rtl/id_ex_operand_stage_if.sv
// ID/EX operand-stage bus: decoded ID fields, MEM/WB forwarding
// sources, and the prepared EX operands and control.
interface id_ex_operand_stage_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic          Stall_ID_EX;
    logic          Flush_ID_EX;
    logic [DW-1:0] Read_Data_1_ID;
    logic [DW-1:0] Read_Data_2_ID;
    logic [DW-1:0] Sign_Extend_ID;
    logic [RW-1:0] Rs_ID;
    logic [RW-1:0] Rt_ID;
    logic [RW-1:0] Rd_ID;
    logic [5:0]    Funct_ID;
    logic [1:0]    ALUOp_ID;
    logic          ALUSrc_ID;
    logic          RegDst_ID;
    logic          RegWrite_ID;
    logic          MemRead_ID;
    logic          MemWrite_ID;
    logic          MemtoReg_ID;
    logic          Branch_ID;
    logic          RegWrite_MEM;
    logic [RW-1:0] Write_Register_MEM;
    logic [DW-1:0] ALU_Result_MEM;
    logic          RegWrite_WB;
    logic [RW-1:0] Write_Register_WB;
    logic [DW-1:0] Write_Data_WB;
    logic [DW-1:0] Read_Data_1_EX;
    logic [DW-1:0] ALU_Data_2_EX;
    logic [3:0]    ALU_Control_EX;
    logic [DW-1:0] Write_Data_EX;
    logic [RW-1:0] Write_Register_EX;
    logic          RegWrite_EX;
    logic          MemRead_EX;
    logic          MemWrite_EX;
    logic          MemtoReg_EX;
    logic          Branch_EX;
    logic          Load_Use_Stall;

    modport master (
        output Stall_ID_EX, Flush_ID_EX,
        output Read_Data_1_ID, Read_Data_2_ID, Sign_Extend_ID,
        output Rs_ID, Rt_ID, Rd_ID, Funct_ID, ALUOp_ID,
        output ALUSrc_ID, RegDst_ID, RegWrite_ID, MemRead_ID,
        output MemWrite_ID, MemtoReg_ID, Branch_ID,
        output RegWrite_MEM, Write_Register_MEM, ALU_Result_MEM,
        output RegWrite_WB, Write_Register_WB, Write_Data_WB,
        input  Read_Data_1_EX, ALU_Data_2_EX, ALU_Control_EX,
        input  Write_Data_EX, Write_Register_EX,
        input  RegWrite_EX, MemRead_EX, MemWrite_EX,
        input  MemtoReg_EX, Branch_EX, Load_Use_Stall
    );

    modport slave (
        input  Stall_ID_EX, Flush_ID_EX,
        input  Read_Data_1_ID, Read_Data_2_ID, Sign_Extend_ID,
        input  Rs_ID, Rt_ID, Rd_ID, Funct_ID, ALUOp_ID,
        input  ALUSrc_ID, RegDst_ID, RegWrite_ID, MemRead_ID,
        input  MemWrite_ID, MemtoReg_ID, Branch_ID,
        input  RegWrite_MEM, Write_Register_MEM, ALU_Result_MEM,
        input  RegWrite_WB, Write_Register_WB, Write_Data_WB,
        output Read_Data_1_EX, ALU_Data_2_EX, ALU_Control_EX,
        output Write_Data_EX, Write_Register_EX,
        output RegWrite_EX, MemRead_EX, MemWrite_EX,
        output MemtoReg_EX, Branch_EX, Load_Use_Stall
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-side forwarding, ALU control
// decode, immediate select and load-use bubble insertion.
module id_ex_operand_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input logic                  Clk,
    input logic                  Reset,
    id_ex_operand_stage_if.slave bus
);
    typedef struct packed {
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [DW-1:0] imm;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] rd;
        logic [5:0]    funct;
        logic [1:0]    aluop;
        logic          alusrc;
        logic          regdst;
        logic          regwrite;
        logic          memread;
        logic          memwrite;
        logic          memtoreg;
        logic          branch;
    } id_ex_t;

    id_ex_t        stage_q, stage_d, id_in;
    logic          load_use;
    logic [DW-1:0] fwd_a, fwd_b;
    logic [3:0]    alu_ctrl;

    assign id_in = '{
        rd1:      bus.Read_Data_1_ID,
        rd2:      bus.Read_Data_2_ID,
        imm:      bus.Sign_Extend_ID,
        rs:       bus.Rs_ID,
        rt:       bus.Rt_ID,
        rd:       bus.Rd_ID,
        funct:    bus.Funct_ID,
        aluop:    bus.ALUOp_ID,
        alusrc:   bus.ALUSrc_ID,
        regdst:   bus.RegDst_ID,
        regwrite: bus.RegWrite_ID,
        memread:  bus.MemRead_ID,
        memwrite: bus.MemWrite_ID,
        memtoreg: bus.MemtoReg_ID,
        branch:   bus.Branch_ID
    };

    assign load_use = stage_q.memread && (stage_q.rt != '0) &&
                      ((stage_q.rt == bus.Rs_ID) || (stage_q.rt == bus.Rt_ID));

    // A bubble is the all-zero bundle: ALUOp 00 decodes to add.
    always_comb begin
        stage_d = stage_q;
        if (bus.Flush_ID_EX)      stage_d = '0;
        else if (bus.Stall_ID_EX) stage_d = stage_q;
        else if (load_use)        stage_d = '0;
        else                      stage_d = id_in;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) stage_q <= '0;
        else       stage_q <= stage_d;
    end

    // MEM is younger than WB, so it wins; r0 is never forwarded.
    always_comb begin
        fwd_a = stage_q.rd1;
        if (bus.RegWrite_MEM && (bus.Write_Register_MEM != '0) &&
            (bus.Write_Register_MEM == stage_q.rs))
            fwd_a = bus.ALU_Result_MEM;
        else if (bus.RegWrite_WB && (bus.Write_Register_WB != '0) &&
                 (bus.Write_Register_WB == stage_q.rs))
            fwd_a = bus.Write_Data_WB;
    end

    always_comb begin
        fwd_b = stage_q.rd2;
        if (bus.RegWrite_MEM && (bus.Write_Register_MEM != '0) &&
            (bus.Write_Register_MEM == stage_q.rt))
            fwd_b = bus.ALU_Result_MEM;
        else if (bus.RegWrite_WB && (bus.Write_Register_WB != '0) &&
                 (bus.Write_Register_WB == stage_q.rt))
            fwd_b = bus.Write_Data_WB;
    end

    always_comb begin
        alu_ctrl = 4'b1111;
        case (stage_q.aluop)
            2'b00: alu_ctrl = 4'b0010;
            2'b01: alu_ctrl = 4'b0110;
            2'b10: begin
                case (stage_q.funct)
                    6'b100000: alu_ctrl = 4'b0010;
                    6'b100010: alu_ctrl = 4'b0110;
                    6'b100100: alu_ctrl = 4'b0000;
                    6'b100101: alu_ctrl = 4'b0001;
                    6'b101010: alu_ctrl = 4'b0111;
                    default:   alu_ctrl = 4'b1111;
                endcase
            end
            default: alu_ctrl = 4'b1111;
        endcase
    end

    assign bus.Read_Data_1_EX    = fwd_a;
    assign bus.ALU_Data_2_EX     = stage_q.alusrc ? stage_q.imm : fwd_b;
    assign bus.Write_Data_EX     = fwd_b;
    assign bus.ALU_Control_EX    = alu_ctrl;
    assign bus.Write_Register_EX = stage_q.regdst ? stage_q.rd : stage_q.rt;
    assign bus.RegWrite_EX       = stage_q.regwrite;
    assign bus.MemRead_EX        = stage_q.memread;
    assign bus.MemWrite_EX       = stage_q.memwrite;
    assign bus.MemtoReg_EX       = stage_q.memtoreg;
    assign bus.Branch_EX         = stage_q.branch;
    assign bus.Load_Use_Stall    = load_use;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: decode table, directed corner
// sequences and randomized traffic against a behavioural model.
module tb_id_ex_operand_stage;
    localparam int DW = 32;
    localparam int RW = 5;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    id_ex_operand_stage_if #(.DW(DW), .RW(RW)) bus ();

    id_ex_operand_stage #(.DW(DW), .RW(RW)) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus.slave)
    );

    typedef struct {
        logic [31:0] a, b, imm;
        logic [4:0]  rs, rt, rd;
        logic [5:0]  funct;
        logic [1:0]  aluop;
        logic        alusrc, regdst, regwrite, memread;
        logic        memwrite, memtoreg, branch;
    } ins_t;

    typedef struct {
        logic [1:0] op;
        logic [5:0] fn;
        logic [3:0] ctrl;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    ins_t m, cur, z;
    vec_t tbl[10];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", n, act, exp);
        end
    endtask

    task automatic drive(input ins_t x);
        cur = x;
        bus.Read_Data_1_ID = x.a;
        bus.Read_Data_2_ID = x.b;
        bus.Sign_Extend_ID = x.imm;
        bus.Rs_ID = x.rs;
        bus.Rt_ID = x.rt;
        bus.Rd_ID = x.rd;
        bus.Funct_ID = x.funct;
        bus.ALUOp_ID = x.aluop;
        bus.ALUSrc_ID = x.alusrc;
        bus.RegDst_ID = x.regdst;
        bus.RegWrite_ID = x.regwrite;
        bus.MemRead_ID = x.memread;
        bus.MemWrite_ID = x.memwrite;
        bus.MemtoReg_ID = x.memtoreg;
        bus.Branch_ID = x.branch;
    endtask

    task automatic set_fwd(input logic mw, input logic [4:0] mr, input logic [31:0] md,
                           input logic ww, input logic [4:0] wr, input logic [31:0] wd);
        bus.RegWrite_MEM = mw;
        bus.Write_Register_MEM = mr;
        bus.ALU_Result_MEM = md;
        bus.RegWrite_WB = ww;
        bus.Write_Register_WB = wr;
        bus.Write_Data_WB = wd;
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] v);
        if (idx == 0) return v;
        if (bus.RegWrite_MEM && bus.Write_Register_MEM == idx) return bus.ALU_Result_MEM;
        if (bus.RegWrite_WB && bus.Write_Register_WB == idx) return bus.Write_Data_WB;
        return v;
    endfunction

    function automatic logic [3:0] ctrl_of(input logic [1:0] op, input logic [5:0] fn);
        if (op == 2'd0) return 4'd2;
        if (op == 2'd1) return 4'd6;
        if (op == 2'd3) return 4'd15;
        case (fn)
            6'd32:   return 4'd2;
            6'd34:   return 4'd6;
            6'd36:   return 4'd0;
            6'd37:   return 4'd1;
            6'd42:   return 4'd7;
            default: return 4'd15;
        endcase
    endfunction

    function automatic logic lu_of();
        return m.memread && m.rt != 0 && (m.rt == cur.rs || m.rt == cur.rt);
    endfunction

    task automatic check_all(input string t);
        logic [31:0] rtv;
        rtv = fwd(m.rt, m.b);
        chk({t, ".A"}, bus.Read_Data_1_EX, fwd(m.rs, m.a));
        chk({t, ".B"}, bus.ALU_Data_2_EX, m.alusrc ? m.imm : rtv);
        chk({t, ".WD"}, bus.Write_Data_EX, rtv);
        chk({t, ".ctrl"}, 32'(bus.ALU_Control_EX), 32'(ctrl_of(m.aluop, m.funct)));
        chk({t, ".WR"}, 32'(bus.Write_Register_EX), 32'(m.regdst ? m.rd : m.rt));
        chk({t, ".ctl"},
            {27'd0, bus.RegWrite_EX, bus.MemRead_EX, bus.MemWrite_EX, bus.MemtoReg_EX, bus.Branch_EX},
            {27'd0, m.regwrite, m.memread, m.memwrite, m.memtoreg, m.branch});
        chk({t, ".LUS"}, 32'(bus.Load_Use_Stall), 32'(lu_of()));
    endtask

    task automatic tick();
        logic lu;
        @(posedge Clk);
        lu = lu_of();
        if (Reset) m = z;
        else if (bus.Flush_ID_EX) m = z;
        else if (bus.Stall_ID_EX) m = m;
        else if (lu) m = z;
        else m = cur;
        #1;
    endtask

    initial begin
        ins_t x;
        z = '{default: '0};
        tbl[0] = '{2'd0, 6'd42, 4'b0010};
        tbl[1] = '{2'd1, 6'd32, 4'b0110};
        tbl[2] = '{2'd3, 6'd32, 4'b1111};
        tbl[3] = '{2'd2, 6'b100000, 4'b0010};
        tbl[4] = '{2'd2, 6'b100010, 4'b0110};
        tbl[5] = '{2'd2, 6'b100100, 4'b0000};
        tbl[6] = '{2'd2, 6'b100101, 4'b0001};
        tbl[7] = '{2'd2, 6'b101010, 4'b0111};
        tbl[8] = '{2'd2, 6'b100111, 4'b1111};
        tbl[9] = '{2'd2, 6'b000000, 4'b1111};

        Reset = 1'b1;
        bus.Stall_ID_EX = 1'b0;
        bus.Flush_ID_EX = 1'b0;
        set_fwd(0, 0, 0, 0, 0, 0);
        drive(z);
        m = z;
        #2;
        chk("rst.ctrl", 32'(bus.ALU_Control_EX), 32'h2);
        check_all("rst");
        tick();
        Reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            x = z;
            x.aluop = tbl[i].op;
            x.funct = tbl[i].fn;
            drive(x);
            tick();
            #2;
            chk($sformatf("dec%0d", i), 32'(bus.ALU_Control_EX), 32'(tbl[i].ctrl));
        end

        x = z;
        x.rs = 1; x.rt = 2; x.rd = 9; x.a = 5; x.b = 7;
        x.aluop = 2; x.funct = 6'b100000; x.regdst = 1; x.regwrite = 1;
        drive(x);
        tick();
        #2;
        chk("radd.A", bus.Read_Data_1_EX, 32'd5);
        chk("radd.B", bus.ALU_Data_2_EX, 32'd7);
        chk("radd.ctrl", 32'(bus.ALU_Control_EX), 32'h2);
        chk("radd.WR", 32'(bus.Write_Register_EX), 32'd9);
        check_all("radd");

        x = z;
        x.rs = 3; x.a = 32'h11; x.rt = 5; x.b = 32'h22;
        drive(x);
        tick();
        set_fwd(1, 3, 32'hAA, 1, 3, 32'hBB);
        #2;
        chk("fwd.mem", bus.Read_Data_1_EX, 32'hAA);
        set_fwd(1, 0, 32'hAA, 1, 3, 32'hBB);
        #1;
        chk("fwd.wb", bus.Read_Data_1_EX, 32'hBB);
        check_all("fwd");
        set_fwd(0, 0, 0, 0, 0, 0);
        x = z;
        x.rs = 0; x.a = 32'h33;
        drive(x);
        tick();
        set_fwd(1, 0, 32'hAA, 1, 0, 32'hBB);
        #2;
        chk("fwd.r0", bus.Read_Data_1_EX, 32'h33);
        set_fwd(0, 0, 0, 0, 0, 0);

        x = z;
        x.rs = 1; x.rt = 4; x.memread = 1; x.regwrite = 1; x.memtoreg = 1; x.aluop = 0;
        drive(x);
        tick();
        x = z;
        x.rs = 4; x.rt = 6; x.rd = 8; x.regdst = 1; x.regwrite = 1; x.aluop = 2; x.funct = 6'd32;
        drive(x);
        #2;
        chk("lu.stall", 32'(bus.Load_Use_Stall), 32'd1);
        check_all("lu0");
        tick();
        #2;
        chk("lu.bubble", 32'(bus.RegWrite_EX), 32'd0);
        check_all("lu1");
        tick();
        #2;
        chk("lu.resume", 32'(bus.RegWrite_EX), 32'd1);

        x = z;
        x.a = 32'h1234; x.regwrite = 1; x.branch = 1;
        drive(x);
        tick();
        x.a = 32'h9999; x.branch = 0;
        drive(x);
        bus.Stall_ID_EX = 1'b1;
        tick();
        tick();
        #2;
        chk("stall.A", bus.Read_Data_1_EX, 32'h1234);
        chk("stall.br", 32'(bus.Branch_EX), 32'd1);
        check_all("stall");
        bus.Flush_ID_EX = 1'b1;
        tick();
        #2;
        chk("flush.rw", 32'(bus.RegWrite_EX), 32'd0);
        chk("flush.A", bus.Read_Data_1_EX, 32'd0);
        bus.Stall_ID_EX = 1'b0;
        bus.Flush_ID_EX = 1'b0;

        x = z;
        x.alusrc = 1; x.imm = 32'hFFFFFFFE; x.rt = 7; x.b = 32'h3; x.regwrite = 1;
        drive(x);
        tick();
        set_fwd(1, 7, 32'h10, 0, 0, 0);
        #2;
        chk("addi.B", bus.ALU_Data_2_EX, 32'hFFFFFFFE);
        chk("addi.WD", bus.Write_Data_EX, 32'h10);
        check_all("addi");
        set_fwd(0, 0, 0, 0, 0, 0);

        x = z;
        x.rs = 2; x.a = 32'h55; x.rd = 3; x.regdst = 1; x.regwrite = 1; x.aluop = 1;
        drive(x);
        tick();
        #3;
        Reset = 1'b1;
        m = z;
        #1;
        chk("arst.A", bus.Read_Data_1_EX, 32'd0);
        chk("arst.ctrl", 32'(bus.ALU_Control_EX), 32'h2);
        chk("arst.rw", 32'(bus.RegWrite_EX), 32'd0);
        chk("arst.WR", 32'(bus.Write_Register_EX), 32'd0);
        check_all("arst");
        tick();
        Reset = 1'b0;

        for (int i = 0; i < 400; i++) begin
            x.a = $urandom; x.b = $urandom; x.imm = $urandom;
            x.rs = 5'($urandom_range(0, 7));
            x.rt = 5'($urandom_range(0, 7));
            x.rd = 5'($urandom_range(0, 31));
            x.funct = ($urandom_range(0, 1) == 0) ? 6'($urandom) : 6'(32 + 2 * $urandom_range(0, 5));
            x.aluop = 2'($urandom);
            x.alusrc = 1'($urandom); x.regdst = 1'($urandom);
            x.regwrite = 1'($urandom); x.memread = ($urandom_range(0, 2) == 0);
            x.memwrite = 1'($urandom); x.memtoreg = 1'($urandom); x.branch = 1'($urandom);
            drive(x);
            bus.Stall_ID_EX = ($urandom_range(0, 7) == 0);
            bus.Flush_ID_EX = ($urandom_range(0, 9) == 0);
            set_fwd(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                    1'($urandom), 5'($urandom_range(0, 7)), $urandom);
            #2;
            check_all($sformatf("rnd%0d", i));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
